frog_mem_bus: RTL

Memory/bus stage directly downstream of the `frog` 4-bit CPU. It consumes the CPU's multiplexed 7-bit output plus write-cycle flag and returns 4-bit instruction/operand nibbles on the CPU data input. It owns a 128×4 memory that resets to NOP (4'h8). An optional host-side loader fills the memory sequentially while the CPU is held.

---
 rtl/frog_mem_bus.sv | 132 +++++++++++++
 1 files changed

// File: rtl/frog_mem_bus.sv
// Memory/bus stage for the frog 4-bit CPU: 128x4 NOP-reset memory, edge-committed writes.
// Optional host loader compiled in with FROG_MEM_LOADER_EN.
module frog_mem_bus #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 4,
  parameter int DEPTH = 128,
  parameter logic [DATA_W-1:0] RESET_NIB = 4'h8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic              wcyc,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        wr_count,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_nib,
  output logic              load_ready,
  output logic              cpu_hold
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] hold_q;
  logic              wcyc_q;
  logic              cpu_en;
  logic              cpu_we;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

`ifdef FROG_MEM_LOADER_EN
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Dropping load_en beats a same-cycle accept.
  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    cpu_hold   = 1'b0;
    ld_we      = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_en) state_nx = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (!load_en) begin
          state_nx = IDLE;
        end else if (load_valid) begin
          ld_we = 1'b1;
          if (ptr == PTR_MAX) state_nx = DONE;
        end
      end
      DONE: begin
        cpu_hold = 1'b1;
        if (!load_en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (state == IDLE && load_en)
      ptr <= '0;
    else if (ld_we && ptr != PTR_MAX)
      ptr <= ptr + 1'b1;
  end

  assign cpu_en  = (state == IDLE);
  assign ld_addr = ptr;
  assign ld_data = load_nib;
`else
  logic unused_load;
  assign unused_load = ^{load_en, load_valid, load_nib};
  assign load_ready  = 1'b0;
  assign cpu_hold    = 1'b0;
  assign ld_we       = 1'b0;
  assign cpu_en      = 1'b1;
  assign ld_addr     = '0;
  assign ld_data     = '0;
`endif

  // One commit per wcyc assertion: rising edge only.
  assign cpu_we  = wcyc & ~wcyc_q & cpu_en;
  assign rd_data = wcyc ? hold_q : mem[bus_in];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_NIB;
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else if (cpu_we) begin
      mem[addr_q] <= bus_in[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      hold_q   <= RESET_NIB;
      wcyc_q   <= 1'b0;
      wr_count <= '0;
    end else begin
      wcyc_q <= wcyc;
      if (!wcyc) begin
        addr_q <= bus_in;
        hold_q <= mem[bus_in];
      end
      if (cpu_we && wr_count != 8'hFF)
        wr_count <= wr_count + 8'd1;
    end
  end

endmodule
